uart_rx: RTL and testbench

- 8N1 UART receiver; the receive-side counterpart to the SoC's serial tx path.
- Oversamples the asynchronous rx line using a clock-cycle bit counter and deserialises LSB-first.
- Presents each received byte on a valid/ready output interface to the memory-mapped peripheral layer.
- Flags framing errors and overruns as single-cycle pulses.

---
 rtl/uart_rx.sv | 169 ++++++++++++++++
 tb/tb_uart_rx.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a valid/ready byte output.
//   The rx line is synchronised through two flops, the start bit is confirmed at
//   mid-bit, and data bits are then sampled one bit period apart, LSB first.
// Ports:
//   clk         system clock
//   reset       asynchronous active-low reset
//   rx_i        serial input, idle high, asynchronous to clk
//   data_o      received byte, valid while valid_o=1
//   valid_o     byte available; cleared when valid_o && ready_i at a posedge
//   ready_i     consumer ready
//   frame_err_o one-cycle pulse when the stop bit is sampled low
//   overrun_o   one-cycle pulse when a byte completes while the previous is unconsumed
//   busy_o      high whenever the receiver is not idle
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 174,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic                 rx_meta;
    logic                 rx_s;
    logic [2:0]           state,   state_n;
    logic [CW-1:0]        cnt,     cnt_n;
    logic [IW-1:0]        bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0] shreg,   shreg_n;
    logic                 byte_done_c;
    logic                 frame_err_c;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
        end
    end

    // FSM and datapath state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
        end
    end

    // Next-state, bit timing and deserialisation.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        bit_idx_n   = bit_idx;
        shreg_n     = shreg;
        byte_done_c = 1'b0;
        frame_err_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    state_n = S_START;
                    cnt_n   = '0;
                end
            end
            S_START: begin
                if (cnt == CNT_HALF) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    // A line back high at mid-start is a glitch, not a frame.
                    state_n   = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt == CNT_FULL) begin
                    cnt_n   = '0;
                    shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
                    if (bit_idx == IDX_LAST) begin
                        state_n = S_STOP;
                    end else begin
                        bit_idx_n = bit_idx + IW'(1);
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_STOP: begin
                if (cnt == CNT_FULL) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        byte_done_c = 1'b1;
                        state_n     = S_IDLE;
                    end else begin
                        frame_err_c = 1'b1;
                        state_n     = S_BREAK;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_BREAK: begin
                // Wait out a held-low line so it is not seen as repeated starts.
                if (rx_s) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Registered outputs: handshake, overrun and error pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            frame_err_o <= frame_err_c;
            overrun_o   <= 1'b0;
            busy_o      <= (state_n != S_IDLE);
            if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
            if (byte_done_c) begin
                // Accept the new byte if the slot is empty or being drained this edge.
                if (!valid_o || ready_i) begin
                    data_o  <= shreg;
                    valid_o <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    localparam int unsigned CPB = 16;

    logic       clk;
    logic       reset;
    logic       rx_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;

    int n_cmp;
    int n_err;

    int cyc;
    int n_valid;
    int n_vhigh;
    int n_ferr;
    int n_ovr;
    int n_busy;
    logic valid_q;
    logic [7:0] vd [0:31];
    int         vt [0:31];

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor: records valid rising edges (data, time) and pulse counts.
    initial begin
        n_valid = 0; n_vhigh = 0; n_ferr = 0; n_ovr = 0; n_busy = 0; valid_q = 1'b0;
    end
    always @(negedge clk) begin
        if (valid_o && !valid_q) begin
            vd[n_valid % 32] <= data_o;
            vt[n_valid % 32] <= cyc;
            n_valid          <= n_valid + 1;
        end
        valid_q <= valid_o;
        if (valid_o)     n_vhigh <= n_vhigh + 1;
        if (frame_err_o) n_ferr  <= n_ferr + 1;
        if (overrun_o)   n_ovr   <= n_ovr + 1;
        if (busy_o)      n_busy  <= n_busy + 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
        n_cmp++;
        assert (obs >= lo && obs <= hi) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Called 1ns after a posedge; returns 1ns after a posedge, each bit CPB cycles.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int t_start);
        rx_i    = 1'b0;
        t_start = cyc;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rx_i = stop_bit;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_i = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    int t0, t1;
    int b_valid, b_vhigh, b_ferr, b_ovr, b_busy;
    int wait_cnt;

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        reset   = 1'b0;
        rx_i    = 1'b1;
        ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data",  int'(data_o), 0);
        check("rst_valid", int'(valid_o), 0);
        check("rst_busy",  int'(busy_o), 0);
        reset = 1'b1;
        idle(5);

        // Frame 0xA5, ready high.
        b_valid = n_valid; b_vhigh = n_vhigh; b_ferr = n_ferr; b_ovr = n_ovr;
        send_frame(8'hA5, 1'b1, t0);
        idle(20);
        check("a5_count", n_valid - b_valid, 1);
        check("a5_data",  int'(vd[b_valid % 32]), 'hA5);
        check_rng("a5_latency", vt[b_valid % 32] - t0, 152, 156);
        check("a5_vhigh", n_vhigh - b_vhigh, 1);
        check("a5_ferr",  n_ferr - b_ferr, 0);
        check("a5_ovr",   n_ovr - b_ovr, 0);
        check("a5_busy",  int'(busy_o), 0);

        // Back-to-back 0x00, 0xFF.
        b_valid = n_valid;
        send_frame(8'h00, 1'b1, t0);
        send_frame(8'hFF, 1'b1, t1);
        idle(20);
        check("b2b_count", n_valid - b_valid, 2);
        check("b2b_data0", int'(vd[b_valid % 32]), 'h00);
        check("b2b_data1", int'(vd[(b_valid + 1) % 32]), 'hFF);
        check_rng("b2b_space", vt[(b_valid + 1) % 32] - vt[b_valid % 32], 159, 161);

        // Start glitch of 3 cycles.
        b_valid = n_valid; b_ferr = n_ferr; b_busy = n_busy;
        rx_i = 1'b0;
        t0   = cyc;
        repeat (3) @(posedge clk);
        #1;
        rx_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        wait_cnt = 0;
        while (busy_o && wait_cnt < 40) begin
            @(posedge clk);
            #1;
            wait_cnt++;
        end
        check_rng("glitch_busy_drop", cyc - t0, 0, 12);
        idle(200);
        check("glitch_busy_seen", (n_busy - b_busy) > 0 ? 1 : 0, 1);
        check("glitch_valid", n_valid - b_valid, 0);
        check("glitch_ferr",  n_ferr - b_ferr, 0);

        // Bad stop bit, line held low, then good frame 0x3C.
        b_valid = n_valid; b_ferr = n_ferr;
        send_frame(8'h3C, 1'b0, t0);
        repeat (40) @(posedge clk);
        #1;
        check("brk_busy_hold", int'(busy_o), 1);
        idle(30);
        check("brk_ferr",  n_ferr - b_ferr, 1);
        check("brk_valid", n_valid - b_valid, 0);
        check("brk_idle",  int'(busy_o), 0);
        send_frame(8'h3C, 1'b1, t0);
        idle(20);
        check("brk_good_count", n_valid - b_valid, 1);
        check("brk_good_data",  int'(vd[b_valid % 32]), 'h3C);
        check("brk_ferr_after", n_ferr - b_ferr, 1);

        // Overrun with ready low.
        b_valid = n_valid; b_ovr = n_ovr;
        ready_i = 1'b0;
        send_frame(8'h11, 1'b1, t0);
        send_frame(8'h22, 1'b1, t1);
        idle(20);
        check("ovr_data",   int'(data_o), 'h11);
        check("ovr_valid",  int'(valid_o), 1);
        check("ovr_rises",  n_valid - b_valid, 1);
        check("ovr_pulses", n_ovr - b_ovr, 1);
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        ready_i = 1'b0;
        check("ovr_drain", int'(valid_o), 0);
        idle(3);
        ready_i = 1'b1;

        // Reset midway through DATA of 0x5A, then good frame 0x96.
        b_valid = n_valid; b_ferr = n_ferr;
        rx_i = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            rx_i = (8'h5A >> i) & 8'h01;
            repeat (CPB) @(posedge clk);
            #1;
        end
        reset = 1'b0;
        rx_i  = 1'b1;
        #1;
        check("mid_rst_data",  int'(data_o), 0);
        check("mid_rst_valid", int'(valid_o), 0);
        check("mid_rst_ferr",  int'(frame_err_o), 0);
        check("mid_rst_ovr",   int'(overrun_o), 0);
        check("mid_rst_busy",  int'(busy_o), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        idle(40);
        check("abort_valid", n_valid - b_valid, 0);
        check("abort_ferr",  n_ferr - b_ferr, 0);
        send_frame(8'h96, 1'b1, t0);
        idle(20);
        check("post_rst_count", n_valid - b_valid, 1);
        check("post_rst_data",  int'(vd[b_valid % 32]), 'h96);
        check("post_rst_busy",  int'(busy_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
